// File: rtl/usb_tx_sequencer.sv
// USB transmit sequencer: frames packets as SYNC, bit-stuffed LSB-first data
// and EOP, pacing every bit on the external bit-time strobe.
module usb_tx_sequencer #(
   parameter logic [7:0] SYNC_BYTE    = 8'h80,
   parameter int         STUFF_RUN    = 6,
   parameter int         EOP_SE0_BITS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_en,
   input  logic       start,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   input  logic       byte_last,
   output logic       byte_ready,
   output logic       enc_en,
   output logic       enc_bit,
   output logic       se0,
   output logic       enc_init,
   output logic       busy,
   output logic       done,
   output logic       underrun
);

   localparam int OW = $clog2(STUFF_RUN + 1);
   localparam int EW = $clog2(EOP_SE0_BITS + 1);
   localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_RUN);
   localparam logic [EW-1:0] EOP_LAST  = EW'(EOP_SE0_BITS - 1);

   typedef enum logic [2:0] {
      IDLE, SYNC, DATA, EOP_SE0, EOP_J
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      shift_q, shift_d;
   logic [2:0]      idx_q, idx_d;
   logic [OW-1:0]   ones_q, ones_d;
   logic [EW-1:0]   eop_cnt_q, eop_cnt_d;
   logic [7:0]      buf_q, buf_d;
   logic            buf_full_q, buf_full_d;
   logic            buf_last_q, buf_last_d;
   logic            last_seen_q, last_seen_d;
   logic            cur_last_q, cur_last_d;
   logic            fin_q, fin_d;
   logic            done_q, done_d;
   logic [OW-1:0]   ones_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         idx_q       <= '0;
         ones_q      <= '0;
         eop_cnt_q   <= '0;
         buf_q       <= '0;
         buf_full_q  <= 1'b0;
         buf_last_q  <= 1'b0;
         last_seen_q <= 1'b0;
         cur_last_q  <= 1'b0;
         fin_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         ones_q      <= ones_d;
         eop_cnt_q   <= eop_cnt_d;
         buf_q       <= buf_d;
         buf_full_q  <= buf_full_d;
         buf_last_q  <= buf_last_d;
         last_seen_q <= last_seen_d;
         cur_last_q  <= cur_last_d;
         fin_q       <= fin_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      ones_d      = ones_q;
      eop_cnt_d   = eop_cnt_q;
      buf_d       = buf_q;
      buf_full_d  = buf_full_q;
      buf_last_d  = buf_last_q;
      last_seen_d = last_seen_q;
      cur_last_d  = cur_last_q;
      fin_d       = fin_q;
      done_d      = 1'b0;
      ones_nx     = '0;
      enc_en      = 1'b0;
      enc_bit     = 1'b0;
      se0         = 1'b0;
      enc_init    = 1'b0;
      underrun    = 1'b0;
      busy        = (state_q != IDLE);
      done        = done_q;
      byte_ready  = (state_q == SYNC || state_q == DATA) &&
                    !buf_full_q && !last_seen_q;

      if (byte_valid && byte_ready) begin
         buf_d       = byte_in;
         buf_full_d  = 1'b1;
         buf_last_d  = byte_last;
         last_seen_d = byte_last;
      end

      unique case (state_q)
         IDLE: begin
            enc_init = 1'b1;
            if (start) begin
               state_d     = SYNC;
               shift_d     = SYNC_BYTE;
               idx_d       = '0;
               ones_d      = '0;
               eop_cnt_d   = '0;
               buf_full_d  = 1'b0;
               last_seen_d = 1'b0;
               cur_last_d  = 1'b0;
               fin_d       = 1'b0;
            end
         end
         SYNC, DATA: begin
            if (bit_en) begin
               enc_en = 1'b1;
               if (ones_q == STUFF_MAX) begin
                  ones_d = '0;
                  if (fin_q) state_d = EOP_SE0;
               end else begin
                  enc_bit = shift_q[0];
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + 3'd1;
                  ones_nx = shift_q[0] ? ones_q + OW'(1) : '0;
                  ones_d  = ones_nx;
                  if (idx_q == 3'd7) begin
                     if (cur_last_q) begin
                        // A run ending exactly on the last bit still owes a stuffed 0
                        if (ones_nx == STUFF_MAX) fin_d = 1'b1;
                        else state_d = EOP_SE0;
                     end else if (buf_full_q) begin
                        shift_d    = buf_q;
                        cur_last_d = buf_last_q;
                        buf_full_d = 1'b0;
                        state_d    = DATA;
                     end else begin
                        underrun = 1'b1;
                        state_d  = EOP_SE0;
                     end
                  end
               end
            end
         end
         EOP_SE0: begin
            se0 = 1'b1;
            if (bit_en) begin
               if (eop_cnt_q == EOP_LAST) begin
                  eop_cnt_d = '0;
                  state_d   = EOP_J;
               end else begin
                  eop_cnt_d = eop_cnt_q + EW'(1);
               end
            end
         end
         EOP_J: begin
            enc_init = 1'b1;
            if (bit_en) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Randomised bench for usb_tx_sequencer against a bit-list model of the
// USB framing and stuffing rules.
module tb_usb_tx_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       bit_en;
   logic       start;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_last;
   logic       byte_ready;
   logic       enc_en;
   logic       enc_bit;
   logic       se0;
   logic       enc_init;
   logic       busy;
   logic       done;
   logic       underrun;

   usb_tx_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .bit_en     (bit_en),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_last  (byte_last),
      .byte_ready (byte_ready),
      .enc_en     (enc_en),
      .enc_bit    (enc_bit),
      .se0        (se0),
      .enc_init   (enc_init),
      .busy       (busy),
      .done       (done),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   int period = 1;
   int ph     = 0;

   initial begin
      bit_en = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ph++;
         if (ph >= period) ph = 0;
         bit_en = (ph == 0);
      end
   end

   bit got_q[$];
   bit exp_q[$];
   int n_ur, n_done, n_se0, n_j, n_viol;

   always @(negedge clk) begin
      if (!rst) begin
         if (enc_en) got_q.push_back(enc_bit);
         if (enc_en && !bit_en) n_viol++;
         if (se0 && enc_init) n_viol++;
         if (underrun) n_ur++;
         if (done) n_done++;
         if (se0 && bit_en) n_se0++;
         if (enc_init && busy && bit_en) n_j++;
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   logic [7:0] pkt [8];

   task automatic build_exp(input int n, input bit ur);
      bit raw[$];
      logic [7:0] sb;
      int ones;
      sb = 8'h80;
      for (int i = 0; i < 8; i++) raw.push_back(sb[i]);
      for (int b = 0; b < n; b++)
         for (int i = 0; i < 8; i++) raw.push_back(pkt[b][i]);
      exp_q.delete();
      ones = 0;
      foreach (raw[i]) begin
         if (ones == 6) begin
            exp_q.push_back(1'b0);
            ones = 0;
         end
         exp_q.push_back(raw[i]);
         ones = raw[i] ? ones + 1 : 0;
      end
      if (!ur && ones == 6) exp_q.push_back(1'b0);
   endtask

   task automatic run_pkt(input int per, input int dly, input int n,
                          input bit ur, input bit overlap);
      int t;
      logic [127:0] g, e;
      period = per;
      got_q.delete();
      n_ur = 0; n_done = 0; n_se0 = 0; n_j = 0; n_viol = 0;
      if (overlap) begin
         start = 1'b1;
      end else begin
         @(posedge clk); #1;
         start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      for (int b = 0; b < n; b++) begin
         t = 0;
         @(negedge clk);
         while (!byte_ready && t < 200) begin
            @(negedge clk);
            t++;
         end
         chk("rdy_wait", byte_ready, 1);
         if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
         end
         byte_in    = pkt[b];
         byte_last  = !ur && (b == n - 1);
         byte_valid = 1'b1;
         @(posedge clk); #1;
         byte_valid = 1'b0;
         byte_last  = 1'b0;
      end
      t = 0;
      @(negedge clk);
      while (!done && t < 5000) begin
         @(negedge clk);
         t++;
      end
      #1;
      build_exp(n, ur);
      g = '0; e = '0;
      foreach (got_q[i]) if (i < 128) g[i] = got_q[i];
      foreach (exp_q[i]) if (i < 128) e[i] = exp_q[i];
      chk("len", got_q.size(), exp_q.size());
      chk("bits", g, e);
      chk("underrun", n_ur, ur);
      chk("done", n_done, 1);
      chk("se0_bits", n_se0, 2);
      chk("j_bits", n_j, 1);
      chk("viol", n_viol, 0);
   endtask

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 5))
         0: return 8'h00;
         1: return 8'hFF;
         2: return 8'hFC;
         3: return 8'h7E;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int n;
      bit ur;
      rst = 1'b1;
      start = 1'b0;
      byte_in = '0;
      byte_valid = 1'b0;
      byte_last = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ur", underrun, 0);
      chk("rst_rdy", byte_ready, 0);
      chk("rst_en", enc_en, 0);
      chk("rst_bit", enc_bit, 0);
      chk("rst_se0", se0, 0);
      chk("rst_init", enc_init, 1);
      rst = 1'b0;

      pkt[0] = 8'h00; run_pkt(1, 0, 1, 0, 0);
      pkt[0] = 8'hFF; run_pkt(1, 0, 1, 0, 0);
      pkt[0] = 8'hFC; run_pkt(1, 0, 1, 0, 1);
      pkt[0] = 8'hA5; run_pkt(1, 1, 1, 1, 0);
      pkt[0] = 8'h00; run_pkt(4, 2, 1, 0, 0);

      for (int k = 0; k < 24; k++) begin
         ur = ($urandom_range(0, 3) == 0);
         n  = ur ? $urandom_range(0, 4) : $urandom_range(1, 5);
         for (int b = 0; b < 5; b++) pkt[b] = pick();
         run_pkt($urandom_range(1, 4), $urandom_range(0, 3), n, ur,
                 1'($urandom_range(0, 1)));
      end

      period = 1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      byte_in = 8'h3C;
      byte_valid = 1'b1;
      @(posedge clk); #1;
      byte_valid = 1'b0;
      repeat (12) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_init", enc_init, 1);
      chk("mid_se0", se0, 0);
      chk("mid_rdy", byte_ready, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      pkt[0] = 8'hFF; pkt[1] = 8'h81;
      run_pkt(2, 1, 2, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/usb_tx_sequencer.md
Name: usb_tx_sequencer

Overview:
Transmit-side controller for the USB serial path. It accepts packet bytes over a valid/ready handshake and frames each packet as SYNC, then data serialized LSB-first, then EOP. It inserts stuffed zeros and drives the per-bit enable, raw bit, SE0 and re-init controls of the downstream NRZI encoder. It paces every transmitted bit on an external bit-time strobe.

Parameters:
SYNC_BYTE, 8'h80, SYNC pattern, sent LSB-first (wire order 0000_0001).
STUFF_RUN, 6, number of consecutive 1s that forces a stuffed 0.
EOP_SE0_BITS, 2, number of bit times SE0 is held during EOP.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
bit_en  in  1  bit-time strobe; one clk-wide pulse per bit time.
start  in  1  request a packet; sampled only in IDLE.
byte_in  in  8  packet byte.
byte_valid  in  1  byte_in is valid.
byte_last  in  1  qualifies byte_in as the final byte of the packet.
byte_ready  out  1  a byte is accepted on any cycle with byte_valid && byte_ready.
enc_en  out  1  the encoder advances one bit this cycle.
enc_bit  out  1  raw (pre-NRZI) bit; meaningful only when enc_en=1.
se0  out  1  drive SE0 on the line; overrides the encoder output.
enc_init  out  1  hold the encoder and line at J (idle) and re-initialise encoder state.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at the end of each packet.
underrun  out  1  one-cycle pulse when a packet is aborted for lack of data.

Behaviour:
- Reset (async, rst=1): state=IDLE, buffer empty, counters cleared. Outputs: busy=0, done=0, underrun=0, byte_ready=0, enc_en=0, enc_bit=0, se0=0, enc_init=1. Reset mid-packet aborts the packet with no EOP.
- States: IDLE, SYNC, DATA, EOP_SE0, EOP_J.
- IDLE: enc_init=1.
  - start=1 -> SYNC on the next cycle; shift register loaded with SYNC_BYTE; bit index=0; ones_cnt=0.
  - start is ignored in every other state.
- Bit emission: only in SYNC/DATA and only on cycles with bit_en=1.
  - enc_en=1 on exactly those cycles; enc_en=0 on all other cycles, and all outputs hold between strobes.
  - If ones_cnt==STUFF_RUN: emit enc_bit=0 as a stuffed bit, set ones_cnt=0, and do not advance the bit index.
  - Otherwise emit shift[0] and advance the index. A 1 increments ones_cnt; a 0 clears it.
  - Stuffing applies across SYNC and data and across byte boundaries.
- One-entry input buffer:
  - byte_ready=1 when the state is SYNC or DATA, the buffer is empty, and byte_last has not yet been accepted.
  - Acceptance fills the buffer and captures byte_last.
- Byte boundary: when bit 7 is emitted, the shift register reloads from the buffer on that same bit_en cycle.
  - SYNC -> DATA transition occurs at the end of SYNC.
  - If the buffer is empty and the last byte has not been seen: pulse underrun, go to EOP_SE0 immediately with no pending stuff bit, and drop any later bytes.
- End of data: after bit 7 of the last byte, if ones_cnt==STUFF_RUN, emit one stuffed 0 on the next bit_en, then go to EOP_SE0. Otherwise go to EOP_SE0 directly.
- EOP_SE0: se0=1, enc_en=0, for EOP_SE0_BITS bit_en strobes; then EOP_J.
- EOP_J: se0=0, enc_init=1, for one bit_en strobe; then done=1 for one cycle and the state returns to IDLE.
- start may be asserted in the cycle done pulses; it is honoured on the following cycle.
- A packet with zero bytes is not legal: the first data fetch with the buffer empty is an underrun.

Test Plan:
1. bit_en=1 every cycle, start, one byte 0x00 with last=1 -> enc_bit stream on enc_en cycles is 0000000100000000, then se0 for 2 cycles, 1 J cycle, then done; busy high throughout.
2. One byte 0xFF, last=1 -> after SYNC the stream is 11111 0 111. The stuffed 0 follows 6 ones (the SYNC 1 plus five data 1s); the total data phase is 9 enc_en cycles, then EOP.
3. One byte 0xFC, last=1 -> stream after SYNC is 00111111 then a stuffed 0, then SE0.
4. First byte 0xA5 with last=0, then byte_valid held 0 -> after 8 data bits, underrun pulses for 1 cycle, SE0 starts, no stuff bit is sent, and done pulses after EOP_J.
5. bit_en every 4th cycle, byte_valid delayed 2 cycles after byte_ready -> enc_en appears only on strobe cycles, outputs are stable between strobes, and the bit stream is identical to scenario 1.
6. rst pulsed during DATA -> on the same cycle busy=0, enc_init=1, se0=0, byte_ready=0; a following start runs a clean packet.
